// File: rtl/buffer_burst_seq.sv
// buffer_burst_seq: burst sequencer between the 512x16 transfer buffer halves and the SDRAM data path.
// Define BUFFER_BURST_SEQ_OVERRUN_EN to build the sticky OVERRUN flag and its port.
module buffer_burst_seq (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        DIR,
    input  logic [8:0]  START_ADDR,
    input  logic [9:0]  LEN,
    input  logic        ABORT,
    output logic        BUSY,
    output logic        DONE,
    output logic [8:0]  RD_BUF_ADDR,
    input  logic [15:0] RD_BUF_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] OUT_DATA,
    input  logic        IN_VALID,
    input  logic [15:0] IN_DATA,
    output logic        WR_BUF_WE,
    output logic [8:0]  WR_BUF_ADDR,
    output logic [15:0] WR_BUF_WD
`ifdef BUFFER_BURST_SEQ_OVERRUN_EN
    ,
    output logic        OVERRUN
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM_OUT,
        S_STREAM_IN,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [8:0]  addr_cnt;
    logic [9:0]  remaining;
    logic [9:0]  len_sat;
    logic        rd_pending;
    logic [1:0]  fifo_count;
    logic [15:0] fifo_head, fifo_tail;
    logic [2:0]  fifo_occ;
    logic        start_acc, issue, push, pop, flush, last_pop, take_in, last_in;

    assign len_sat   = (LEN > 10'd512) ? 10'd512 : LEN;
    assign start_acc = (state == S_IDLE) && START;
    assign flush     = (state != S_IDLE) && ABORT;

    // Occupancy seen by the next read: buffered words plus the one in flight, minus this cycle's pop.
    assign push     = rd_pending;
    assign pop      = OUT_VALID && OUT_READY;
    assign fifo_occ = {1'b0, fifo_count} + {2'b00, rd_pending} - {2'b00, pop};
    assign issue    = (state == S_STREAM_OUT) && !ABORT && (remaining != 10'd0) && (fifo_occ < 3'd2);
    assign last_pop = (state == S_STREAM_OUT) && pop && (fifo_count == 2'd1) && !rd_pending
                      && (remaining == 10'd0);
    assign take_in  = (state == S_STREAM_IN) && IN_VALID && !ABORT;
    assign last_in  = take_in && (remaining == 10'd1);

    assign BUSY        = (state == S_STREAM_OUT) || (state == S_STREAM_IN);
    assign DONE        = (state == S_DONE);
    assign OUT_VALID   = (fifo_count != 2'd0);
    assign OUT_DATA    = fifo_head;
    assign RD_BUF_ADDR = addr_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    if (len_sat == 10'd0) state_nxt = S_DONE;
                    else if (DIR)         state_nxt = S_STREAM_IN;
                    else                  state_nxt = S_STREAM_OUT;
                end
            end
            S_STREAM_OUT: begin
                if (ABORT)         state_nxt = S_IDLE;
                else if (last_pop) state_nxt = S_DONE;
            end
            S_STREAM_IN: begin
                if (ABORT)        state_nxt = S_IDLE;
                else if (last_in) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_cnt   <= 9'd0;
            remaining  <= 10'd0;
            rd_pending <= 1'b0;
        end else begin
            if (start_acc && (len_sat != 10'd0)) begin
                addr_cnt  <= START_ADDR;
                remaining <= len_sat;
            end else if (issue || take_in) begin
                addr_cnt  <= addr_cnt + 9'd1;
                remaining <= remaining - 10'd1;
            end
            rd_pending <= issue;
        end
    end

    // NOTE: the two FIFO entries drive OUT_DATA directly, so they are reset like any other output register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fifo_count <= 2'd0;
            fifo_head  <= 16'd0;
            fifo_tail  <= 16'd0;
        end else if (flush) begin
            fifo_count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) fifo_head <= RD_BUF_DATA;
                    else                    fifo_tail <= RD_BUF_DATA;
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_head  <= fifo_tail;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_head <= RD_BUF_DATA;
                    end else begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= RD_BUF_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // A strobe captured before an abort still produces its write in the following cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WR_BUF_WE   <= 1'b0;
            WR_BUF_ADDR <= 9'd0;
            WR_BUF_WD   <= 16'd0;
        end else begin
            WR_BUF_WE <= take_in;
            if (take_in) begin
                WR_BUF_ADDR <= addr_cnt;
                WR_BUF_WD   <= IN_DATA;
            end
        end
    end

`ifdef BUFFER_BURST_SEQ_OVERRUN_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                  OVERRUN <= 1'b0;
        else if (start_acc)                         OVERRUN <= 1'b0;
        else if (IN_VALID && (state != S_STREAM_IN)) OVERRUN <= 1'b1;
    end
`endif

endmodule
